// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM driving datapath controls.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcode/funct parks the FSM in TRAP until rst.
module mips_control_fsm #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    output logic             br,
    output logic             regdst,
    output logic             enable,
    output logic             alusrc,
    output logic [31:0]      sign,
    output logic [3:0]       sel,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             pc_en,
    output logic             ir_en,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExecute, StMemory, StWriteback, StTrap
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [3:0] SelAdd  = 4'b0010;
    localparam logic [3:0] SelSub  = 4'b0110;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e IllegalNext = StTrap;
`else
    localparam state_e IllegalNext = StFetch;
`endif

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    logic [5:0]  opcode, funct;
    logic [3:0]  rsel;
    logic        funct_ok, opcode_ok;
    logic [31:0] sign_c;
    logic        br_c, regdst_c, enable_c, alusrc_c, memread_c, memwrite_c;
    logic        memtoreg_c, pc_en_c, ir_en_c, done_c;
    logic [3:0]  sel_c;

    // rs/rt/rd fields are consumed by the datapath, not by control.
    logic unused_ir;
    assign unused_ir = ^ir_q[25:16];

    assign opcode    = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign sign_c    = {{(32-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
    assign opcode_ok = opcode inside {OpRtype, OpLw, OpSw, OpBeq, OpAddi};

    always_comb begin
        rsel     = 4'b0000;
        funct_ok = 1'b1;
        unique case (funct)
            6'h20:   rsel = SelAdd;
            6'h22:   rsel = SelSub;
            6'h24:   rsel = 4'b0000;
            6'h25:   rsel = 4'b0001;
            6'h2A:   rsel = 4'b0111;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        br_c       = 1'b0;
        regdst_c   = 1'b0;
        enable_c   = 1'b0;
        alusrc_c   = 1'b0;
        sel_c      = 4'b0000;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        memtoreg_c = 1'b0;
        pc_en_c    = 1'b0;
        ir_en_c    = 1'b0;
        done_c     = 1'b0;
        unique case (state_q)
            StFetch: begin
                ir_en_c = 1'b1;
                pc_en_c = 1'b1;
                ir_d    = instr;
                state_d = StDecode;
            end
            StDecode: begin
                illegal_d = !opcode_ok;
                state_d   = opcode_ok ? StExecute : IllegalNext;
            end
            StExecute: begin
                unique case (opcode)
                    OpRtype: begin
                        sel_c = rsel;
                        if (funct_ok) begin
                            state_d = StWriteback;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = IllegalNext;
                        end
                    end
                    OpLw, OpSw: begin
                        alusrc_c = 1'b1;
                        sel_c    = SelAdd;
                        state_d  = StMemory;
                    end
                    OpAddi: begin
                        alusrc_c = 1'b1;
                        sel_c    = SelAdd;
                        state_d  = StWriteback;
                    end
                    OpBeq: begin
                        sel_c   = SelSub;
                        br_c    = 1'b1;
                        done_c  = 1'b1;
                        state_d = StFetch;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMemory: begin
                if (opcode == OpLw) begin
                    memread_c = 1'b1;
                    alusrc_c  = 1'b1;
                    sel_c     = SelAdd;
                    state_d   = StWriteback;
                end else begin
                    memwrite_c = 1'b1;
                    done_c     = 1'b1;
                    state_d    = StFetch;
                end
            end
            StWriteback: begin
                enable_c = 1'b1;
                done_c   = 1'b1;
                state_d  = StFetch;
                if (opcode == OpRtype) begin
                    regdst_c = 1'b1;
                    sel_c    = rsel;
                end else begin
                    memtoreg_c = (opcode == OpLw);
                    alusrc_c   = 1'b1;
                    sel_c      = SelAdd;
                end
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
        retired_d = done_c ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // All outputs read 0 while reset is asserted, even though the reset state is FETCH.
    always_comb begin
        br       = !rst && br_c;
        regdst   = !rst && regdst_c;
        enable   = !rst && enable_c;
        alusrc   = !rst && alusrc_c;
        memread  = !rst && memread_c;
        memwrite = !rst && memwrite_c;
        memtoreg = !rst && memtoreg_c;
        pc_en    = !rst && pc_en_c;
        ir_en    = !rst && ir_en_c;
        done     = !rst && done_c;
        illegal  = !rst && illegal_q;
        sel      = rst ? 4'b0000 : sel_c;
        sign     = rst ? 32'h0 : sign_c;
        retired  = rst ? '0 : retired_q;
    end

endmodule

// File: doc/mips_control_fsm.md
Name: mips_control_fsm

Overview:
- Multicycle control unit that drives the DATAPATH control inputs: br, regdst, enable, alusrc, sign and sel.
- Takes the 32-bit instruction word from instruction memory and latches it into an internal IR.
- Walks a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine and emits per-state control so the datapath executes one instruction at a time.
- Also provides memory strobes, PC/IR enables, a retire pulse and a retired-instruction counter for the bench.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- IMM_W, 16, immediate field width; sign is sign-extended from IMM_W to 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- instr  input  32  instruction word from instruction memory; sampled only in FETCH.
- br  output  1  branch request to datapath; datapath ANDs it with ALU zero.
- regdst  output  1  1 = write register rd[15:11], 0 = rt[20:16].
- enable  output  1  register-file write enable.
- alusrc  output  1  0 = ALU B from register, 1 = from sign.
- sign  output  32  sign-extended IR[15:0].
- sel  output  4  ALU operation select.
- memread  output  1  data-memory read strobe.
- memwrite  output  1  data-memory write strobe.
- memtoreg  output  1  1 = write-back data from memory.
- pc_en  output  1  PC <= PC+4 this cycle.
- ir_en  output  1  IR load this cycle.
- done  output  1  one-cycle pulse on the instruction's last state.
- retired  output  CNT_W  count of completed instructions.
- illegal  output  1  last decoded opcode unsupported (sticky until next DECODE).

Behaviour:
- Reset (rst=1 at clk edge): state<=FETCH, IR<=0, retired<=0, illegal<=0. The reset takes priority over any in-flight instruction, which is abandoned with no partial write.
- Reset values of all outputs: 0, including sign=0 because IR=0.
- Control outputs are Moore, decoded from state and IR. Any output not listed for a state is 0.
- sign = {{(32-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]}. It is valid in every state after FETCH.
- FETCH: ir_en=1, pc_en=1; IR<=instr. Next state DECODE.
- DECODE: classify IR[31:26]. Supported opcodes are 0x00 R-type, 0x23 lw, 0x2B sw, 0x04 beq, 0x08 addi. Any other opcode sets illegal=1 and goes to FETCH with done=0. Otherwise illegal<=0 and next state is EXECUTE.
- EXECUTE:
  - R-type: alusrc=0; sel from funct (0x20->0010, 0x22->0110, 0x24->0000, 0x25->0001, 0x2A->0111). An unknown funct sets illegal=1 and goes to FETCH.
  - lw/sw/addi: alusrc=1, sel=0010.
  - beq: alusrc=0, sel=0110, br=1, done=1; next state FETCH.
  - All others: next state MEMORY for lw/sw, WRITEBACK for R-type/addi.
- MEMORY:
  - lw: memread=1, sel/alusrc held; next state WRITEBACK.
  - sw: memwrite=1, done=1; next state FETCH.
- WRITEBACK: enable=1, sel/alusrc held.
  - regdst=1 for R-type, 0 for lw/addi.
  - memtoreg=1 for lw only.
  - done=1; next state FETCH.
- Latency in cycles, FETCH to done inclusive: R-type 4, addi 4, lw 5, sw 4, beq 3.
- retired increments on every done pulse and wraps from 2^CNT_W-1 to 0.
- Illegal instructions: do not increment retired; enable/memwrite are never asserted for them.
- instr changes outside FETCH are ignored.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode/funct moves to a TRAP state. TRAP holds illegal=1, all other controls 0, pc_en=0, until rst.
- Undefined: illegal instruction is treated as a NOP. illegal=1 is flagged and the FSM returns to FETCH as described above.

Test Plan:
- rst=1 one cycle, then instr=0x00221820 (add $3,$1,$2). Required sequence:
  - cycle 1: ir_en=pc_en=1.
  - cycle 3: sel=0010, alusrc=0.
  - cycle 4: enable=1, regdst=1, done=1.
  - afterwards: retired=1.
- instr=0x20040006 (addi $4,$0,6): sign=6, sel=0010, alusrc=1; WRITEBACK has enable=1, regdst=0; 4 cycles total.
- instr=0x8C020010 (lw) then 0xAC020014 (sw):
  - lw: memread=1 in cycle 4, memtoreg=enable=1 in cycle 5.
  - sw: memwrite=1, done=1 in cycle 4, enable never 1.
  - retired +2.
- instr=0x1022FFFF (beq): sign=0xFFFFFFFF, br=1, sel=0110, done=1 in cycle 3; enable/memwrite stay 0.
- instr=0xFC000000:
  - macro off: illegal=1 after DECODE, back in FETCH at cycle 3, retired unchanged.
  - macro on: pc_en stays 0 and illegal=1 for 10+ cycles, until rst clears it.
- Retire and reset corners:
  - preload retired=0xFFFF (CNT_W=16) via 65535 NOPs or force, retire one add -> retired=0.
  - assert rst during MEMORY of lw -> next cycle FETCH with all controls 0 and no enable pulse.
